// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin with bounded lock
// bursts, alignment/range checking and a registered response one cycle after grant.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        rerr0,
  output logic        rerr1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam int unsigned CntW      = $clog2(MAX_LOCK + 1);
  localparam logic [31:0] AddrLimit = 32'(DEPTH * 4);

  logic            rr_q;        // 1 = port 1 preferred on contention
  logic            lock_vld_q;
  logic            lock_own_q;
  logic [CntW-1:0] lock_cnt_q;

  logic        sel;
  logic        gnt_any;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        sel_lock;
  logic        other_req;
  logic        legal;

  // Grants are forced low in reset so nothing reaches the memory.
  always_comb begin
    sel  = 1'b0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (lock_vld_q && (lock_cnt_q < CntW'(MAX_LOCK))) sel = lock_own_q;
        else                                             sel = rr_q;
        gnt0 = !sel;
        gnt1 = sel;
      end
    end
  end

  always_comb begin
    gnt_any   = gnt0 | gnt1;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    sel_we    = gnt1 ? we1    : we0;
    sel_lock  = gnt1 ? lock1  : lock0;
    other_req = gnt1 ? req0   : req1;
    legal     = (sel_addr[1:0] == 2'b00) && (sel_addr < AddrLimit);
    mem_a     = sel_addr;
    mem_wd    = sel_wdata;
    mem_we    = gnt_any & sel_we & legal;
  end

  // The lock counter includes the acquiring grant, so an owner gets MAX_LOCK
  // contended grants before the other port wins the round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
    end else if (gnt_any) begin
      rr_q <= !gnt1;
      if (!sel_lock) begin
        lock_vld_q <= 1'b0;
        lock_cnt_q <= '0;
      end else if (lock_vld_q && (lock_own_q == gnt1)) begin
        if (other_req) lock_cnt_q <= lock_cnt_q + CntW'(1);
      end else begin
        lock_vld_q <= 1'b1;
        lock_own_q <= gnt1;
        lock_cnt_q <= CntW'(other_req);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rerr0   <= 1'b0;
      rerr1   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      rerr0   <= gnt0 & !legal;
      rerr1   <= gnt1 & !legal;
      if (gnt0) rdata0 <= (legal && !we0) ? mem_rd : 32'h0;
      if (gnt1) rdata1 <= (legal && !we1) ? mem_rd : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural 64-word memory attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  dmem_arbiter #(.DEPTH(64), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rerr0(rerr0), .rerr1(rerr1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  typedef struct {
    logic        r0, r1, w0, w1, l0, l1;
    logic [31:0] a0, a1, d0, d1;
    logic        g0, g1, mwe;
    logic        rv0, rv1, re0, re1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1; lock0 = v.l0; lock1 = v.l1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    //       r0 r1 w0 w1 l0 l1  a0     a1     d0            d1           g0 g1 we rv0 rv1 re0 re1 rd0 rd1
    vecs.push_back('{1,0,0,0,0,0, 32'h8, 32'h0, 32'h0, 32'h0,        1,0,0, 1,0,0,0, 32'h0, 32'h0});
    vecs.push_back('{1,0,1,0,0,0, 32'h10,32'h0, 32'h12345678,32'h0, 1,0,1, 1,0,0,0, 32'h0, 32'h0});
    vecs.push_back('{1,0,0,0,0,0, 32'h10,32'h0, 32'h0, 32'h0,        1,0,0, 1,0,0,0, 32'h12345678, 32'h0});
    vecs.push_back('{1,0,1,0,0,0, 32'h4, 32'h0, 32'h11111111,32'h0, 1,0,1, 1,0,0,0, 32'h0, 32'h0});
    vecs.push_back('{0,1,0,1,0,0, 32'h0, 32'hFC,32'h0, 32'h22222222,  0,1,1, 0,1,0,0, 32'h0, 32'h0});
    vecs.push_back('{1,0,1,0,0,0, 32'h6, 32'h0, 32'hBAD0BAD0,32'h0,  1,0,0, 1,0,1,0, 32'h0, 32'h0});
    vecs.push_back('{1,0,1,0,0,0, 32'h100,32'h0,32'hBAD1BAD1,32'h0,  1,0,0, 1,0,1,0, 32'h0, 32'h0});
    vecs.push_back('{1,0,0,0,0,0, 32'h4, 32'h0, 32'h0, 32'h0,        1,0,0, 1,0,0,0, 32'h11111111, 32'h0});
    vecs.push_back('{0,1,0,0,0,0, 32'h0, 32'hFC,32'h0, 32'h0,        0,1,0, 0,1,0,0, 32'h11111111, 32'h22222222});
    vecs.push_back('{0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0,        0,0,0, 0,0,0,0, 32'h11111111, 32'h22222222});
    vecs.push_back('{0,1,0,0,0,0, 32'h0, 32'h200,32'h0,32'h0,        0,1,0, 0,1,0,1, 32'h11111111, 32'h0});
    // Contention without lock: strict alternation starting at port 0.
    for (int k = 0; k < 3; k++) begin
      vecs.push_back('{1,1,0,0,0,0, 32'h4, 32'hFC,32'h0, 32'h0,      1,0,0, 1,0,0,0, 32'h11111111,
                       (k == 0) ? 32'h0 : 32'h22222222});
      vecs.push_back('{1,1,0,0,0,0, 32'h4, 32'hFC,32'h0, 32'h0,      0,1,0, 0,1,0,0, 32'h11111111, 32'h22222222});
    end
    // Single port-0 grant points round-robin at port 1 before the lock burst.
    vecs.push_back('{1,0,0,0,0,0, 32'h10,32'h0, 32'h0, 32'h0,        1,0,0, 1,0,0,0, 32'h12345678, 32'h22222222});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1,1,0,0,0,1, 32'h4, 32'hFC,32'h0, 32'h0,      0,1,0, 0,1,0,0, 32'h12345678, 32'h22222222});
    vecs.push_back('{1,1,0,0,0,1, 32'h4, 32'hFC,32'h0, 32'h0,        1,0,0, 1,0,0,0, 32'h11111111, 32'h22222222});
    vecs.push_back('{1,1,0,0,0,1, 32'h4, 32'hFC,32'h0, 32'h0,        0,1,0, 0,1,0,0, 32'h11111111, 32'h22222222});

    // Reset with a pending write request: no grant, no memory write.
    rst_n = 1'b0;
    req0 = 1; req1 = 0; we0 = 1; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 32'h8; addr1 = 32'h0; wdata0 = 32'hDEADBEEF; wdata1 = 32'h0;
    #3;
    chk("rst gnt0", {31'b0, gnt0}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst rvalid0", {31'b0, rvalid0}, 32'h0);
    chk("rst rerr0", {31'b0, rerr0}, 32'h0);
    chk("rst rdata0", rdata0, 32'h0);
    chk("rst rdata1", rdata1, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req0 = 0; we0 = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), {31'b0, gnt0}, {31'b0, vecs[i].g0});
      chk($sformatf("v%0d gnt1", i), {31'b0, gnt1}, {31'b0, vecs[i].g1});
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].mwe});
      @(posedge clk); #1;
      chk($sformatf("v%0d rvalid0", i), {31'b0, rvalid0}, {31'b0, vecs[i].rv0});
      chk($sformatf("v%0d rvalid1", i), {31'b0, rvalid1}, {31'b0, vecs[i].rv1});
      chk($sformatf("v%0d rerr0", i), {31'b0, rerr0}, {31'b0, vecs[i].re0});
      chk($sformatf("v%0d rerr1", i), {31'b0, rerr1}, {31'b0, vecs[i].re1});
      chk($sformatf("v%0d rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("v%0d rdata1", i), rdata1, vecs[i].rd1);
    end

    // Reset while rvalid1 is high; port 1 also holds a fresh lock at this point.
    rst_n = 1'b0;
    #1;
    chk("midrst rvalid1", {31'b0, rvalid1}, 32'h0);
    chk("midrst rdata1", rdata1, 32'h0);
    chk("midrst gnt1", {31'b0, gnt1}, 32'h0);
    chk("midrst mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst gnt0", {31'b0, gnt0}, 32'h1);
    chk("postrst gnt1", {31'b0, gnt1}, 32'h0);
    @(posedge clk); #1;
    chk("postrst rvalid0", {31'b0, rvalid0}, 32'h1);
    chk("postrst rvalid1", {31'b0, rvalid1}, 32'h0);
    chk("postrst rdata0", rdata0, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (64 words, combinational read, write on clock edge) between two requesters.
  - Port 0: core load/store unit.
  - Port 1: DMA/program loader.
- Arbitrates with round-robin fairness plus bounded lock bursts.
- Checks alignment and range before driving the memory.
- Returns a registered response one cycle after grant.
- Sits between the requesters and the data memory's A/WD/WE/RD pins.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached memory; legal byte addresses are 0 to DEPTH*4-1.
- MAX_LOCK, 4, maximum consecutive grants one port may hold via lock while the other port is requesting.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0 / req1  input  1  access request from port 0 / port 1.
- we0 / we1  input  1  1 = write, 0 = read.
- lock0 / lock1  input  1  requests that the grant be kept on the next cycle.
- addr0 / addr1  input  32  byte address.
- wdata0 / wdata1  input  32  write data.
- gnt0 / gnt1  output  1  request accepted this cycle (combinational).
- rvalid0 / rvalid1  output  1  response valid, one cycle after gnt.
- rerr0 / rerr1  output  1  response is an error (misaligned or out of range).
- rdata0 / rdata1  output  32  read data, valid with rvalid on a non-error read.
- mem_a  output  32  memory address.
- mem_wd  output  32  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  32  memory read data (combinational from mem_a).

Behaviour:
- Reset (rst_n low, asynchronous):
  - rvalid0/1, rerr0/1 = 0; rdata0/1 = 0.
  - Round-robin pointer = port 0 preferred; lock counter = 0; lock owner = none.
  - While rst_n is low: gnt0/1 = 0 and mem_we = 0 (combinationally forced), so no memory write occurs during reset.
- Grant decision (combinational, each cycle, at most one grant):
  - One port requesting: it is granted.
  - Both requesting, active lock owner and lock counter < MAX_LOCK: lock owner is granted.
  - Both requesting, otherwise: the port indicated by the round-robin pointer is granted.
- Pointer update (registered, on a cycle with a grant): pointer moves to the port not granted. No update on idle cycles.
- Lock:
  - Lock owner becomes the granted port if its lock input is high; otherwise it is cleared.
  - Lock counter increments on each consecutive grant to the same owner while the other port is requesting.
  - Lock counter resets to 0 when ownership changes or is cleared.
  - On reaching MAX_LOCK with the other port requesting, the other port is granted next, ownership is cleared and the counter resets.
  - With the other port idle, a locked port may hold indefinitely.
- Memory drive:
  - mem_a = granted port's addr; mem_wd = granted port's wdata.
  - mem_we = gnt & we & legal.
  - legal = (addr[1:0] == 0) && (addr < DEPTH*4).
  - With no grant: mem_a holds the port-0 addr, mem_we = 0.
- Response (registered, at the grant edge):
  - rvalidN = 1 for exactly one cycle after gntN, for reads and writes.
  - rerrN = !legal.
  - rdataN = mem_rd for legal reads; 0 for writes and errors.
  - rdata holds its value until the next response on that port.
- Illegal write: mem_we stays 0, memory unchanged, rerr = 1.
- Throughput: one access per cycle; back-to-back grants to the same port are allowed with a new rvalid each cycle.
- Read after write to the same address, granted on consecutive cycles: the read returns the new data.
- A write and a read in the same cycle cannot happen (single grant).
- Reset asserted mid-response: rvalid drops immediately; no response is replayed after reset.

Test Plan:
- Reset with req0=1, we0=1, addr0=0x8, wdata0=0xDEADBEEF, then release reset and read addr 0x8 -> during reset gnt0=0, mem_we=0; after release the read returns rdata0=0x00000000.
- Port 0 writes 0x12345678 to addr 0x10, then port 0 reads 0x10 on the next cycle:
  - gnt0=1 in both cycles.
  - rvalid0=1 in cycles N+1 and N+2.
  - Second response has rdata0=0x12345678, rerr0=0.
- Both ports request reads on 6 consecutive cycles with lock low -> grants alternate 0,1,0,1,0,1; each port receives 3 rvalids.
- Port 1 holds lock1=1 while port 0 also requests, MAX_LOCK=4 -> gnt1 for 4 cycles, then gnt0 for 1 cycle, then port 1 may re-acquire.
- Port 0 writes addr 0x6 (misaligned), then port 0 writes addr 0x100 (out of range, DEPTH=64):
  - mem_we=0 in both cycles.
  - rvalid0=1 with rerr0=1 for each.
  - Subsequent reads of 0x4 and 0xFC return unchanged contents.
- Assert rst_n low for one cycle while rvalid1 is high -> rvalid1 drops to 0 asynchronously; pointer returns to port 0, so a next simultaneous request grants port 0.
